muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the execute stage of the single-cycle core, alongside alu.
- Consumes the same op1/op2 operands as alu and feeds the writeback result mux.
- Holds the pipeline via busy/done.
- Shift-add multiply and restoring divide, one bit per cycle, with sign correction and RISC-V special cases.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Operation encodings, FSM states and operand-sign helpers.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    function automatic logic is_signed_op1(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b010) ||
               (op == 3'b100) || (op == 3'b110);
    endfunction

    function automatic logic is_signed_op2(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// Magnitudes are processed unsigned; signs are restored in the FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    state_e             state;
    state_e             state_nx;
    muldiv_op_e         op_q;
    logic               s1_q;
    logic               s2_q;
    logic               div0_q;
    logic               ovf_q;
    logic [WIDTH-1:0]   op1_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   quo_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH:0]     rem_q;
    logic [CW-1:0]      cnt_q;

    logic               accept;
    logic               sgn1;
    logic               sgn2;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic               div0;
    logic               ovf;
    logic               last;
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod_f;
    logic [WIDTH-1:0]   quo_f;
    logic [WIDTH-1:0]   rem_f;
    logic [WIDTH-1:0]   fix_res;

    assign accept  = start && (state == IDLE || state == DONE);
    assign sgn1    = is_signed_op1(op) & op1[WIDTH-1];
    assign sgn2    = is_signed_op2(op) & op2[WIDTH-1];
    assign abs1    = sgn1 ? -op1 : op1;
    assign abs2    = sgn2 ? -op2 : op2;
    assign div0    = op[2] && (op2 == '0);
    assign ovf     = op[2] && !op[0] &&
                     (op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (op2 == '1);
    assign last    = (cnt_q == CW'(WIDTH-1));

    assign msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     {1'b0, (acc_q[0] ? opb_q : '0)};
    assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, opb_q};

    assign prod_f  = (s1_q ^ s2_q) ? -acc_q : acc_q;
    assign quo_f   = (s1_q ^ s2_q) ? -quo_q : quo_q;
    assign rem_f   = s1_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    assign busy    = (state == CALC) || (state == FIX);
    assign done    = (state == DONE);

    // Final result selection with special-case overrides
    always_comb begin
        fix_res = '0;
        unique case (op_q)
            OP_MUL:    fix_res = prod_f[WIDTH-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  fix_res = prod_f[2*WIDTH-1:WIDTH];
            OP_DIV,
            OP_DIVU:   fix_res = div0_q ? '1 : (ovf_q ? op1_q : quo_f);
            OP_REM,
            OP_REMU:   fix_res = div0_q ? op1_q : (ovf_q ? '0 : rem_f);
            default:   fix_res = '0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = (div0 || ovf) ? FIX : CALC;
            CALC: if (last) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: begin
                if (accept) state_nx = (div0 || ovf) ? FIX : CALC;
                else        state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Operand capture, per-bit iteration and result register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q   <= OP_MUL;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            div0_q <= 1'b0;
            ovf_q  <= 1'b0;
            op1_q  <= '0;
            opb_q  <= '0;
            quo_q  <= '0;
            acc_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                op_q   <= muldiv_op_e'(op);
                s1_q   <= sgn1;
                s2_q   <= sgn2;
                div0_q <= div0;
                ovf_q  <= ovf;
                op1_q  <= op1;
                opb_q  <= abs2;
                quo_q  <= abs1;
                acc_q  <= {{WIDTH{1'b0}}, abs1};
                rem_q  <= '0;
                cnt_q  <= '0;
            end else if (state == CALC) begin
                acc_q  <= {msum, acc_q[WIDTH-1:1]};
                rem_q  <= trial[WIDTH] ? shifted : trial;
                quo_q  <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_q  <= cnt_q + CW'(1);
            end
            if (state == FIX) result <= fix_res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scenario-driven bench for muldiv_unit.
// Expected results are queued at issue and popped when done pulses.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .op(op),
        .op1(op1),
        .op2(op2),
        .busy(busy),
        .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint     sa = $signed(a);
        longint     sb = $signed(b);
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ub = {32'b0, b};
        logic [63:0] p;
        logic        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ov) return a;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ov) return 32'h0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Called at a negedge; drives one accept edge and leaves at the next negedge.
    task automatic launch(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e,
                          input bit push);
        start = 1'b1;
        op = o;
        op1 = a;
        op2 = b;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom);
        op1 = $urandom;
        op2 = $urandom;
    endtask

    // Sample at negedges from edge n0 on; lat=-1 if done never arrives.
    task automatic wait_done(input int n0, output int lat, output int bcnt,
                             output bit ovl, output logic [31:0] res);
        int n = n0;
        lat = -1;
        bcnt = 0;
        ovl = 1'b0;
        res = 'x;
        while (n <= 60) begin
            if (busy && done) ovl = 1'b1;
            if (done) begin
                lat = n;
                res = result;
                break;
            end
            if (busy) bcnt++;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pop_exp(output logic [31:0] e);
        e = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b1;
        op = 3'b100;
        op1 = 32'd9;
        op2 = 32'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b exp=0", busy);
        end
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL reset_done got=%b exp=0", done);
        end
        total++;
        if (result !== '0) begin
            bad++; $display("FAIL reset_result got=%h exp=0", result);
        end
        start = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        int lat, bcnt;
        bit ovl;
        logic [31:0] res, e;
        launch(OP_MUL, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1);
        wait_done(0, lat, bcnt, ovl, res);
        pop_exp(e);
        total++;
        if (res !== e) begin
            bad++; $display("FAIL mul_result got=%h exp=%h", res, e);
        end
        total++;
        if (lat != 33) begin
            bad++; $display("FAIL mul_latency got=%0d exp=33", lat);
        end
        total++;
        if (bcnt != 33) begin
            bad++; $display("FAIL mul_busy_cycles got=%0d exp=33", bcnt);
        end
        total++;
        if (ovl) begin
            bad++; $display("FAIL mul_busy_done_overlap got=1 exp=0");
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL mul_done_pulse got=%b exp=0", done);
        end
    endtask

    task automatic test_mulh();
        logic [2:0]  o[3] = '{3'b001, 3'b011, 3'b010};
        logic [31:0] a[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] b[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] x[3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        int lat, bcnt;
        bit ovl;
        logic [31:0] res, e;
        for (int i = 0; i < 3; i++) begin
            launch(o[i], a[i], b[i], x[i], 1);
            wait_done(0, lat, bcnt, ovl, res);
            pop_exp(e);
            total++;
            if (res !== e || lat != 33) begin
                bad++;
                $display("FAIL mulh[%0d] got=%h lat=%0d exp=%h lat=33",
                         i, res, lat, e);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  o[4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] a[4] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20, 32'd20};
        logic [31:0] b[4] = '{32'd3, 32'd3, 32'd3, 32'd3};
        logic [31:0] x[4] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd6, 32'd2};
        int lat, bcnt;
        bit ovl;
        logic [31:0] res, e;
        for (int i = 0; i < 4; i++) begin
            launch(o[i], a[i], b[i], x[i], 1);
            wait_done(0, lat, bcnt, ovl, res);
            pop_exp(e);
            total++;
            if (res !== e || lat != 33) begin
                bad++;
                $display("FAIL div[%0d] got=%h lat=%0d exp=%h lat=33",
                         i, res, lat, e);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  o[4] = '{3'b100, 3'b111, 3'b100, 3'b110};
        logic [31:0] a[4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b[4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] x[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int lat, bcnt;
        bit ovl;
        logic [31:0] res, e;
        for (int i = 0; i < 4; i++) begin
            launch(o[i], a[i], b[i], x[i], 1);
            wait_done(0, lat, bcnt, ovl, res);
            pop_exp(e);
            total++;
            if (res !== e) begin
                bad++; $display("FAIL special_res[%0d] got=%h exp=%h", i, res, e);
            end
            total++;
            if (lat != 1 || bcnt != 1 || ovl) begin
                bad++;
                $display("FAIL special_timing[%0d] got lat=%0d busy=%0d exp lat=1 busy=1",
                         i, lat, bcnt);
            end
        end
    endtask

    task automatic test_ignore_and_abort();
        int lat, bcnt, pulses;
        bit ovl;
        logic [31:0] res, e;
        launch(OP_DIVU, 32'd100, 32'd7, 32'd14, 1);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b1;
        op = 3'b000;
        op1 = 32'd50;
        op2 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(5, lat, bcnt, ovl, res);
        pop_exp(e);
        total++;
        if (res !== e || lat != 33) begin
            bad++;
            $display("FAIL ignore_start got=%h lat=%0d exp=%h lat=33", res, lat, e);
        end
        @(posedge clk);
        @(negedge clk);
        launch(OP_MUL, 32'd5, 32'd6, 32'd30, 0);
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            bad++;
            $display("FAIL abort_state got busy=%b done=%b res=%h exp 0/0/0",
                     busy, done, result);
        end
        reset_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++; $display("FAIL abort_no_done got=%0d exp=0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        bit ovl;
        logic [31:0] res, e;
        launch(OP_DIVU, 32'd9, 32'd2, 32'd4, 1);
        wait_done(0, lat, bcnt, ovl, res);
        pop_exp(e);
        total++;
        if (res !== e || lat != 33) begin
            bad++; $display("FAIL b2b_first got=%h lat=%0d exp=%h lat=33", res, lat, e);
        end
        launch(OP_MUL, 32'd3, 32'd4, 32'd12, 1);
        wait_done(0, lat, bcnt, ovl, res);
        pop_exp(e);
        total++;
        if (res !== e || lat != 33 || bcnt != 33) begin
            bad++;
            $display("FAIL b2b_second got=%h lat=%0d busy=%0d exp=%h lat=33 busy=33",
                     res, lat, bcnt, e);
        end
    endtask

    task automatic test_random();
        int lat, bcnt;
        bit ovl;
        logic [31:0] a, b, res, e;
        logic [2:0] o;
        for (int i = 0; i < 12; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (i == 3) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            launch(o, a, b, model(o, a, b), 1);
            wait_done(0, lat, bcnt, ovl, res);
            pop_exp(e);
            total++;
            if (res !== e || lat < 0 || ovl) begin
                bad++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h lat=%0d exp=%h",
                         i, o, a, b, res, lat, e);
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_ignore_and_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
